wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4, meaning number of execution units sharing the writeback port (legal range 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port unit_done  input  NUM_UNITS  per-unit result-pending flag, held high by each unit until acked.
REQ-005 SHALL have port unit_id  input  NUM_UNITS x id_t  per-unit instruction id.
REQ-006 SHALL have port unit_phys_addr  input  NUM_UNITS x phys_addr_t (6)  per-unit destination physical register.
REQ-007 SHALL have port unit_data  input  NUM_UNITS x 32  per-unit result data.
REQ-008 SHALL have port writeback_supress  input  1  global-control suppression; no grants while high.
REQ-009 SHALL have port unit_ack  output  NUM_UNITS  one-hot-or-zero grant, combinational, same cycle as accepted unit_done.
REQ-010 SHALL have port wb  output  wb_packet_t (id, phys_addr, valid, data)  registered writeback to the register file.

Function
REQ-011 SHALL keep a round-robin pointer ptr in 0..NUM_UNITS-1.
REQ-012 SHALL grant the first unit with unit_done high, searching ptr, ptr+1, ... wrapping modulo NUM_UNITS.
REQ-013 SHALL assert at most one unit_ack bit per cycle, and none when no unit_done is high or writeback_supress is high.
REQ-014 SHALL on a grant to unit g set ptr to (g+1) mod NUM_UNITS at the next edge; wrap from NUM_UNITS-1 to 0.
REQ-015 SHALL leave ptr unchanged in any cycle without a grant.
REQ-016 SHALL on a grant to unit g load wb.id/phys_addr/data from unit g and set wb.valid=1 at the next edge (latency exactly 1 cycle, ack to valid).
REQ-017 SHALL set wb.valid=0 at the next edge in any cycle without a grant; wb.id/phys_addr/data hold their last values.
REQ-018 SHALL sustain one writeback per cycle with back-to-back grants, including consecutive grants to the same unit when it is the sole requester.
REQ-019 SHALL treat unit_done and writeback_supress arriving together as suppressed: no ack, ptr unchanged, wb.valid=0 next cycle.
REQ-020 SHALL ignore unit_id/phys_addr/data of units not granted.
REQ-021 SHALL not depend on unit_done dropping without an ack; such a drop is legal, simply yields no grant.

Reset
REQ-022 SHALL while rst high drive unit_ack=0 combinationally and, at the edge, set ptr=0, wb.valid=0, wb.id=0, wb.phys_addr=0, wb.data=0.
REQ-023 SHALL on rst asserted mid-stream discard the pending registered writeback (wb.valid=0 next cycle) and grant nothing that cycle.
REQ-024 SHALL after rst deassert give unit 0 highest priority first.

Structure
REQ-025 SHALL take id_t, phys_addr_t and wb_packet_t from the shared cva5_types package; NUM_UNITS-dependent widths are local.
REQ-026 SHALL place any new shared writeback-unit-count constant in cva5_config, not in the module.
REQ-027 SHALL implement the round-robin search as one sub-module, wb_rr_grant (inputs requests, ptr; outputs one-hot grant and encoded index).
REQ-028 SHALL contain exactly one pipeline register stage (the wb packet) plus ptr; no FIFOs.

Verification
REQ-029 SHALL cover: reset, then unit_done=4'b1111 held, units re-asserting after ack -> acks 0,1,2,3,0 on successive cycles, wb.valid=1 each cycle from cycle 2.
REQ-030 SHALL cover: only unit 2 requesting for 3 cycles, data 0x11,0x22,0x33 -> ack[2] each cycle, wb.data 0x11,0x22,0x33 one cycle later, ptr=3.
REQ-031 SHALL cover: ptr=3, unit_done=4'b1001 -> ack unit 3, then unit 0 (wrap), ptr ends at 1.
REQ-032 SHALL cover: unit_done=4'b0110 with writeback_supress=1 for 2 cycles -> no acks, wb.valid=0, ptr unchanged; on release ack unit 1.
REQ-033 SHALL cover: rst asserted the cycle after a grant of id=5, phys_addr=9 -> wb.valid=0, wb.id=0, wb.phys_addr=0 after the edge, ptr=0.
REQ-034 SHALL check every cycle: $onehot0(unit_ack), and unit_ack bit set implies unit_done bit set.

Source files
------------

// File: rtl/cva5_config.sv
// Shared build-time configuration constants for the cva5 core slice.
package cva5_config;
  localparam int unsigned LOG2_MAX_IDS       = 3;
  localparam int unsigned PHYS_ADDR_W        = 6;
  localparam int unsigned MAX_WB_UNITS       = 8;
  localparam int unsigned DEFAULT_WB_UNITS   = 4;
endpackage

// File: rtl/cva5_types.sv
// Shared cva5 datapath types used across the writeback path.
package cva5_types;
  import cva5_config::*;

  typedef logic [LOG2_MAX_IDS-1:0] id_t;
  typedef logic [PHYS_ADDR_W-1:0]  phys_addr_t;

  typedef struct packed {
    id_t         id;
    phys_addr_t  phys_addr;
    logic        valid;
    logic [31:0] data;
  } wb_packet_t;
endpackage

// File: rtl/wb_arbiter_pkg.sv
// Helpers local to the writeback arbiter.
package wb_arbiter_pkg;
  // Modular add for a < n and b < n, avoiding a divider for non-power-of-two n.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Execution-unit / register-file side of the writeback arbiter.
interface wb_arbiter_if
  import cva5_types::*;
#(
  parameter int unsigned NUM_UNITS = cva5_config::DEFAULT_WB_UNITS
);
  logic [NUM_UNITS-1:0]                 unit_done;
  id_t [NUM_UNITS-1:0]                  unit_id;
  phys_addr_t [NUM_UNITS-1:0]           unit_phys_addr;
  logic [NUM_UNITS-1:0][31:0]           unit_data;
  logic                                 writeback_supress;
  logic [NUM_UNITS-1:0]                 unit_ack;
  wb_packet_t                           wb;

  modport master (
    input  unit_done, unit_id, unit_phys_addr, unit_data, writeback_supress,
    output unit_ack, wb
  );

  modport slave (
    output unit_done, unit_id, unit_phys_addr, unit_data, writeback_supress,
    input  unit_ack, wb
  );
endinterface

// File: rtl/wb_rr_grant.sv
// Round-robin search: first request at or after ptr, wrapping; one-hot grant plus index.
module wb_rr_grant
  import wb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_UNITS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] requests,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_UNITS-1:0] grant,
  output logic [IDX_W-1:0]     idx
);
  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      cand = IDX_W'(wrap_add(32'(ptr), i, NUM_UNITS));
      if (!found && requests[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one registered writeback port among NUM_UNITS execution units.
module wb_arbiter
  import cva5_types::*;
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS = cva5_config::DEFAULT_WB_UNITS
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0] requests;
  logic [NUM_UNITS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     ptr_next;
  logic                 granted;
  wb_packet_t           wb_q;
  wb_packet_t           wb_next;

  // Reset and suppression both mask every request so no ack can escape.
  assign requests = (rst || bus.writeback_supress) ? '0 : bus.unit_done;

  wb_rr_grant #(.NUM_UNITS(NUM_UNITS)) u_rr_grant (
    .requests (requests),
    .ptr      (ptr),
    .grant    (grant),
    .idx      (grant_idx)
  );

  always_comb begin
    granted       = |grant;
    ptr_next      = ptr;
    wb_next       = wb_q;
    wb_next.valid = 1'b0;
    if (granted) begin
      ptr_next          = IDX_W'(wrap_add(32'(grant_idx), 32'd1, NUM_UNITS));
      wb_next.id        = bus.unit_id[grant_idx];
      wb_next.phys_addr = bus.unit_phys_addr[grant_idx];
      wb_next.data      = bus.unit_data[grant_idx];
      wb_next.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      wb_q <= '0;
    end else begin
      ptr  <= ptr_next;
      wb_q <= wb_next;
    end
  end

  assign bus.unit_ack = grant;
  assign bus.wb       = wb_q;
endmodule
